sample_uart_streamer: RTL

Parametrised successor to the single-channel SPI-sampler-to-UART test loop. It triggers the multi-channel ADC sampler periodically, latches the N-channel sample word, and streams a framed binary record over the UART byte interface. It sits between `sampler` and `uart` in the clk100 domain. It adds channel-count and sample-width generality, an enable gate, overrun detection and a frame counter.

---
 rtl/sample_uart_streamer_if.sv | 33 +++
 rtl/sample_uart_streamer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/sample_uart_streamer_if.sv
// Handshake bundle between the streamer, the multi-channel sampler and the UART byte port.
// DATA_W must equal NUM_CH*SAMPLE_W of the attached streamer.
interface sample_uart_streamer_if #(
    parameter int DATA_W = 24
);
    logic              sampler_start;
    logic              sampler_busy;
    logic              sampler_new_data;
    logic [DATA_W-1:0] sampler_data;
    logic [7:0]        tx_byte;
    logic              tx_en;
    logic              tx_ready;

    modport master (
        output sampler_start,
        output tx_byte,
        output tx_en,
        input  sampler_busy,
        input  sampler_new_data,
        input  sampler_data,
        input  tx_ready
    );

    modport slave (
        input  sampler_start,
        input  tx_byte,
        input  tx_en,
        output sampler_busy,
        output sampler_new_data,
        output sampler_data,
        output tx_ready
    );
endinterface

// File: rtl/sample_uart_streamer.sv
// Periodically triggers the N-channel sampler and streams each latched sample word as a framed UART record.
// Defining STREAMER_CHECKSUM_EN appends an XOR checksum byte to every frame.
module sample_uart_streamer #(
    parameter int         NUM_CH    = 2,
    parameter int         SAMPLE_W  = 12,
    parameter int         PERIOD    = 65000,
    parameter logic [7:0] SYNC_BYTE = 8'hAA
) (
    input  logic                   clk100,
    input  logic                   rst,
    input  logic                   enable_i,
    sample_uart_streamer_if.master bus,
    output logic                   busy_o,
    output logic                   overrun_o,
    output logic [15:0]            frame_count_o
);
    localparam int DATA_W = NUM_CH * SAMPLE_W;
    localparam int CNT_W  = $clog2(PERIOD);
    localparam int IDX_W  = 4;
`ifdef STREAMER_CHECKSUM_EN
    localparam int FRAME_LEN = 2 + 2 * NUM_CH;
`else
    localparam int FRAME_LEN = 1 + 2 * NUM_CH;
`endif
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_TX_LOAD = 2'd2;
    localparam logic [1:0] ST_TX_GAP  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              start_q, start_d;
    logic              tx_en_q, tx_en_d;
    logic [7:0]        tx_byte_q, tx_byte_d;
    logic              busy_q, busy_d;
    logic              overrun_q, overrun_d;
    logic [15:0]       frame_count_q, frame_count_d;
    logic              tick_s;
    logic [7:0]        byte_s;
    logic [7:0]        frame_s [2**IDX_W];
    logic              unused_busy_s;

    // Upper sample bits, zero-extended into one byte.
    function automatic logic [7:0] hi_f(input logic [SAMPLE_W-1:0] s);
        return 8'(s >> 8);
    endfunction

`ifdef STREAMER_CHECKSUM_EN
    // XOR of every payload byte; the sync byte is excluded.
    function automatic logic [7:0] csum_f(input logic [DATA_W-1:0] d);
        logic [7:0] c;
        c = 8'h00;
        for (int k = 0; k < NUM_CH; k++) begin
            c = c ^ hi_f(d[k*SAMPLE_W +: SAMPLE_W]) ^ d[k*SAMPLE_W +: 8];
        end
        return c;
    endfunction
`endif

    assign unused_busy_s = bus.sampler_busy;
    assign tick_s        = enable_i && (cnt_q == CNT_LAST);

    // Frame byte table built from the latched sample word.
    always_comb begin
        for (int i = 0; i < 2**IDX_W; i++) begin
            frame_s[i] = 8'h00;
        end
        frame_s[0] = SYNC_BYTE;
        for (int k = 0; k < NUM_CH; k++) begin
            frame_s[1 + 2*k] = hi_f(data_q[k*SAMPLE_W +: SAMPLE_W]);
            frame_s[2 + 2*k] = data_q[k*SAMPLE_W +: 8];
        end
`ifdef STREAMER_CHECKSUM_EN
        frame_s[1 + 2*NUM_CH] = csum_f(data_q);
`endif
        byte_s = frame_s[idx_q];
    end

    // Period counter and sticky overrun flag; both cleared while disabled.
    always_comb begin
        cnt_d     = '0;
        overrun_d = 1'b0;
        if (enable_i) begin
            cnt_d     = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
            overrun_d = overrun_q | (tick_s && (state_q != ST_IDLE));
        end else begin
            cnt_d     = '0;
            overrun_d = 1'b0;
        end
    end

    // Frame sequencer; a tick outside IDLE is dropped so the running frame always completes.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        data_d        = data_q;
        start_d       = 1'b0;
        tx_en_d       = 1'b0;
        tx_byte_d     = tx_byte_q;
        frame_count_d = frame_count_q;
        case (state_q)
            ST_IDLE: begin
                if (tick_s) begin
                    state_d = ST_REQ;
                    start_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (bus.sampler_new_data) begin
                    data_d  = bus.sampler_data;
                    idx_d   = '0;
                    state_d = ST_TX_LOAD;
                end else begin
                    start_d = 1'b1;
                end
            end
            ST_TX_LOAD: begin
                if (bus.tx_ready) begin
                    tx_byte_d = byte_s;
                    tx_en_d   = 1'b1;
                    state_d   = ST_TX_GAP;
                end else begin
                    state_d = ST_TX_LOAD;
                end
            end
            ST_TX_GAP: begin
                if (idx_q == LAST_IDX) begin
                    frame_count_d = frame_count_q + 16'd1;
                    state_d       = ST_IDLE;
                end else begin
                    idx_d   = idx_q + 4'd1;
                    state_d = ST_TX_LOAD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset aborts any frame without a stray strobe.
    always_ff @(posedge clk100 or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            idx_q         <= '0;
            data_q        <= '0;
            start_q       <= 1'b0;
            tx_en_q       <= 1'b0;
            tx_byte_q     <= 8'h00;
            busy_q        <= 1'b0;
            overrun_q     <= 1'b0;
            frame_count_q <= 16'h0000;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            data_q        <= data_d;
            start_q       <= start_d;
            tx_en_q       <= tx_en_d;
            tx_byte_q     <= tx_byte_d;
            busy_q        <= busy_d;
            overrun_q     <= overrun_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign bus.sampler_start = start_q;
    assign bus.tx_en         = tx_en_q;
    assign bus.tx_byte       = tx_byte_q;
    assign busy_o            = busy_q;
    assign overrun_o         = overrun_q;
    assign frame_count_o     = frame_count_q;
endmodule
